// File: rtl/gbp_update_queue.sv
// gbp_update_queue
//   In-order buffer for resolved conditional-branch updates on their way from
//   EXECUTE to the global branch predictor. It also holds the committed global
//   history register, which changes only when an update is drained.
//
//   Ports
//     clk_i, rst_i        clock, asynchronous active-high reset
//     flush_bp_i          empties the queue and clears the GHR (highest priority)
//     debug_mode_i        blocks new updates; queued entries keep draining
//     upd_valid_i/pc/index/taken   incoming resolved update
//     stall_i             predictor cannot take the head this cycle
//     out_valid_o/pc/index/taken   head entry presented to the predictor
//     ghr_o               committed global history, LSB = newest
//     count_o             occupancy
//     drop_cnt_o          saturating count of updates lost to overflow
module gbp_update_queue #(
  parameter int DEPTH    = 4,
  parameter int VLEN     = 64,
  parameter int INDEX_W  = 9,
  parameter int GHR_BITS = 9,
  parameter int DROP_W   = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_bp_i,
  input  logic                       debug_mode_i,
  input  logic                       upd_valid_i,
  input  logic [VLEN-1:0]            upd_pc_i,
  input  logic [INDEX_W-1:0]         upd_index_i,
  input  logic                       upd_taken_i,
  input  logic                       stall_i,
  output logic                       out_valid_o,
  output logic [VLEN-1:0]            out_pc_o,
  output logic [INDEX_W-1:0]         out_index_o,
  output logic                       out_taken_o,
  output logic [GHR_BITS-1:0]        ghr_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [DROP_W-1:0]          drop_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Entry storage: plain flops, not reset (contents are only meaningful
  // between rd_ptr and wr_ptr, and the pointers are reset).
  logic [VLEN-1:0]    pc_mem_q    [DEPTH];
  logic [INDEX_W-1:0] index_mem_q [DEPTH];
  logic               taken_mem_q [DEPTH];

  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q,  count_d;
  logic [GHR_BITS-1:0] ghr_q,    ghr_d;
  logic [DROP_W-1:0]   drop_q,   drop_d;

  logic push, pop, full, head_vld;

  assign head_vld = (count_q != '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign push     = upd_valid_i & ~debug_mode_i & ~flush_bp_i;
  assign pop      = head_vld & ~stall_i & ~flush_bp_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ghr_d    = ghr_q;
    drop_d   = drop_q;

    if (flush_bp_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ghr_d    = '0;
    end else begin
      if (pop) begin
        ghr_d = {ghr_q[GHR_BITS-2:0], taken_mem_q[rd_ptr_q]};
      end
      if (push && pop) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        rd_ptr_d = rd_ptr_q + 1'b1;
      end else if (push && !full) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        count_d  = count_q + 1'b1;
      end else if (push) begin
        // Full and not draining: the oldest entry is overwritten, so the
        // read pointer moves past it together with the write pointer.
        wr_ptr_d = wr_ptr_q + 1'b1;
        rd_ptr_d = rd_ptr_q + 1'b1;
        if (drop_q != '1) begin
          drop_d = drop_q + 1'b1;
        end
      end else if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        count_d  = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ghr_q    <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ghr_q    <= ghr_d;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= upd_pc_i;
      index_mem_q[wr_ptr_q] <= upd_index_i;
      taken_mem_q[wr_ptr_q] <= upd_taken_i;
    end
  end

  // Head is read straight from storage; a fresh push is never forwarded.
  assign out_valid_o = head_vld;
  assign out_pc_o    = head_vld ? pc_mem_q[rd_ptr_q]    : '0;
  assign out_index_o = head_vld ? index_mem_q[rd_ptr_q] : '0;
  assign out_taken_o = head_vld ? taken_mem_q[rd_ptr_q] : 1'b0;
  assign ghr_o       = ghr_q;
  assign count_o     = count_q;
  assign drop_cnt_o  = drop_q;

endmodule

// File: tb/tb_gbp_update_queue.sv
module tb_gbp_update_queue;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        flush_bp_i = 1'b0;
  logic        debug_mode_i = 1'b0;
  logic        upd_valid_i = 1'b0;
  logic [63:0] upd_pc_i = '0;
  logic [8:0]  upd_index_i = '0;
  logic        upd_taken_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        out_valid_o;
  logic [63:0] out_pc_o;
  logic [8:0]  out_index_o;
  logic        out_taken_o;
  logic [8:0]  ghr_o;
  logic [2:0]  count_o;
  logic [7:0]  drop_cnt_o;

  gbp_update_queue dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_bp_i   (flush_bp_i),
    .debug_mode_i (debug_mode_i),
    .upd_valid_i  (upd_valid_i),
    .upd_pc_i     (upd_pc_i),
    .upd_index_i  (upd_index_i),
    .upd_taken_i  (upd_taken_i),
    .stall_i      (stall_i),
    .out_valid_o  (out_valid_o),
    .out_pc_o     (out_pc_o),
    .out_index_o  (out_index_o),
    .out_taken_o  (out_taken_o),
    .ghr_o        (ghr_o),
    .count_o      (count_o),
    .drop_cnt_o   (drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [63:0] pc;
    logic [8:0]  idx;
    logic        taken;
  } ent_t;

  ent_t       sb[$];
  logic [8:0] m_ghr;
  logic [7:0] m_drop;
  int         n_chk  = 0;
  int         n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic [63:0] pc, input logic [8:0] idx,
                       input logic tk);
    upd_valid_i = v;
    upd_pc_i    = pc;
    upd_index_i = idx;
    upd_taken_i = tk;
  endtask

  // Compare current outputs with the reference, then advance the reference
  // by the inputs currently driven and step one clock. Called at a negedge.
  task automatic do_cycle();
    logic do_push, do_pop;
    int   sz;
    ent_t e;
    sz = sb.size();
    chk("count", 64'(count_o), 64'(sz));
    chk("valid", 64'(out_valid_o), 64'(sz != 0));
    chk("ghr",   64'(ghr_o), 64'(m_ghr));
    chk("drop",  64'(drop_cnt_o), 64'(m_drop));
    if (sz != 0) begin
      chk("head_pc",    out_pc_o, sb[0].pc);
      chk("head_idx",   64'(out_index_o), 64'(sb[0].idx));
      chk("head_taken", 64'(out_taken_o), 64'(sb[0].taken));
    end else begin
      chk("idle_pc", out_pc_o, 64'h0);
    end

    do_push = upd_valid_i & ~debug_mode_i & ~flush_bp_i;
    do_pop  = (sz != 0) & ~stall_i & ~flush_bp_i;
    e.pc = upd_pc_i; e.idx = upd_index_i; e.taken = upd_taken_i;
    if (flush_bp_i) begin
      sb.delete();
      m_ghr = '0;
    end else begin
      if (do_pop) begin
        m_ghr = {m_ghr[7:0], sb[0].taken};
        void'(sb.pop_front());
      end
      if (do_push) begin
        if (!do_pop && sz == DEPTH) begin
          void'(sb.pop_front());
          if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
        end
        sb.push_back(e);
      end
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic idle();
    drive(1'b0, 64'h0, 9'h0, 1'b0);
    do_cycle();
  endtask

  task automatic push1(input logic [63:0] pc, input logic [8:0] idx, input logic tk);
    drive(1'b1, pc, idx, tk);
    do_cycle();
  endtask

  // Asserted away from the clock edge, so outputs must clear immediately.
  task automatic do_reset();
    rst_i = 1'b1;
    drive(1'b0, 64'h0, 9'h0, 1'b0);
    stall_i = 1'b0; flush_bp_i = 1'b0; debug_mode_i = 1'b0;
    #2;
    chk("rst_valid", 64'(out_valid_o), 64'h0);
    chk("rst_count", 64'(count_o), 64'h0);
    chk("rst_ghr",   64'(ghr_o), 64'h0);
    chk("rst_drop",  64'(drop_cnt_o), 64'h0);
    chk("rst_pc",    out_pc_o, 64'h0);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    sb.delete();
    m_ghr  = '0;
    m_drop = '0;
  endtask

  initial begin
    logic [7:0] pat;
    m_ghr = '0; m_drop = '0;
    @(negedge clk_i);
    do_reset();

    // 1: single push, presented the next cycle only
    push1(64'h1000, 9'd5, 1'b1);
    chk("t1_valid", 64'(out_valid_o), 64'h1);
    chk("t1_pc", out_pc_o, 64'h1000);
    idle();
    idle();
    chk("t1_ghr", 64'(ghr_o), 64'h001);
    chk("t1_count", 64'(count_o), 64'h0);

    // 2: stalled burst of four, then in-order drain
    do_reset();
    stall_i = 1'b1;
    push1(64'h100, 9'd1, 1'b1);
    push1(64'h104, 9'd2, 1'b0);
    push1(64'h108, 9'd3, 1'b1);
    push1(64'h10C, 9'd4, 1'b1);
    chk("t2_count", 64'(count_o), 64'h4);
    stall_i = 1'b0;
    for (int i = 0; i < 4; i++) idle();
    chk("t2_ghr", 64'(ghr_o), 64'h00B);
    chk("t2_empty", 64'(count_o), 64'h0);

    // 3: overflow overwrites the oldest, drop counter saturates
    stall_i = 1'b1;
    for (int i = 0; i < 4; i++) push1(64'hA0 + 64'(i), 9'(i), i[0]);
    push1(64'h2000, 9'd7, 1'b0);
    chk("t3_head", out_pc_o, 64'hA1);
    chk("t3_count", 64'(count_o), 64'h4);
    chk("t3_drop", 64'(drop_cnt_o), 64'h1);
    for (int i = 0; i < 300; i++) push1(64'h3000 + 64'(i), 9'(i), i[1]);
    idle();
    chk("t3_drop_sat", 64'(drop_cnt_o), 64'hFF);
    stall_i = 1'b0;
    for (int i = 0; i < 4; i++) idle();

    // 4: full queue, push and pop together
    do_reset();
    stall_i = 1'b1;
    for (int i = 0; i < 4; i++) push1(64'hB0 + 64'(i), 9'(i + 8), 1'b1);
    stall_i = 1'b0;
    push1(64'h4000, 9'd9, 1'b0);
    chk("t4_drop", 64'(drop_cnt_o), 64'h0);
    chk("t4_count", 64'(count_o), 64'h4);
    chk("t4_head", out_pc_o, 64'hB1);
    for (int i = 0; i < 3; i++) idle();
    chk("t4_tail", out_pc_o, 64'h4000);
    idle();

    // 5: debug mode blocks pushes but not draining
    stall_i = 1'b1;
    push1(64'hC0, 9'd1, 1'b1);
    push1(64'hC4, 9'd2, 1'b0);
    stall_i = 1'b0;
    debug_mode_i = 1'b1;
    for (int i = 0; i < 3; i++) push1(64'hDEAD, 9'd3, 1'b1);
    chk("t5_count", 64'(count_o), 64'h0);
    debug_mode_i = 1'b0;
    idle();

    // 6: build ghr=0x0A5 with one drop, hold three entries, flush with a push
    do_reset();
    stall_i = 1'b1;
    pat = 8'hA5;
    push1(64'hE00, 9'd0, 1'b1);
    for (int i = 0; i < 4; i++) push1(64'hE10 + 64'(i), 9'(i), pat[7 - i]);
    stall_i = 1'b0;
    for (int i = 4; i < 8; i++) push1(64'hE20 + 64'(i), 9'(i), pat[7 - i]);
    for (int i = 0; i < 4; i++) idle();
    chk("t6_ghr_pre", 64'(ghr_o), 64'h0A5);
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) push1(64'hF00 + 64'(i), 9'(i), 1'b1);
    flush_bp_i = 1'b1;
    push1(64'hF10, 9'd1, 1'b1);
    flush_bp_i = 1'b0;
    chk("t6_count", 64'(count_o), 64'h0);
    chk("t6_valid", 64'(out_valid_o), 64'h0);
    chk("t6_ghr", 64'(ghr_o), 64'h0);
    chk("t6_drop", 64'(drop_cnt_o), 64'h1);
    idle();

    // asynchronous reset while entries are still queued
    stall_i = 1'b1;
    push1(64'h5000, 9'd1, 1'b1);
    push1(64'h5004, 9'd2, 1'b1);
    stall_i = 1'b0;
    do_reset();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
